// File: rtl/led_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : led_arbiter_if
// Description : Bundles the LED arbiter's source inputs and its registered
//               LED and status outputs.
//               master : drives the sources and reads the status (bench or SoC)
//               slave  : the arbiter itself
//   anim_enable   in   1  animation source may own the LEDs
//   anim_leds     in   8  animation engine pattern
//   cpu_we        in   1  single-cycle CPU write strobe
//   cpu_data      in   8  CPU LED value (valid with cpu_we)
//   flash_req     in   1  single-cycle temporary-pattern request
//   flash_pattern in   8  flash value (valid with flash_req)
//   leds          out  8  registered LED drive
//   animating     out  1  owner is ANIM
//   owner         out  2  00 ANIM, 01 CPU, 10 FLASH
//   flash_busy    out  1  owner is FLASH
// Revision    : 1.0 - initial release
// ============================================================================
interface led_arbiter_if;
  logic       anim_enable;
  logic [7:0] anim_leds;
  logic       cpu_we;
  logic [7:0] cpu_data;
  logic       flash_req;
  logic [7:0] flash_pattern;
  logic [7:0] leds;
  logic       animating;
  logic [1:0] owner;
  logic       flash_busy;

  modport master (
    output anim_enable, anim_leds, cpu_we, cpu_data, flash_req, flash_pattern,
    input  leds, animating, owner, flash_busy
  );

  modport slave (
    input  anim_enable, anim_leds, cpu_we, cpu_data, flash_req, flash_pattern,
    output leds, animating, owner, flash_busy
  );
endinterface
`default_nettype wire

// File: rtl/led_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : led_arbiter
// Description : Arbitrates ownership of an 8-bit LED bank between an animation
//               engine, a CPU register and a timed flash pattern.
//               Priority: flash_req > cpu_we > idle timeout / anim_enable.
//   clock    in   sole clock, rising edge
//   reset_b  in   synchronous active-low reset
//   bus      slave modport of led_arbiter_if (sources in, LED/status out)
// Revision    : 1.0 - initial release
// ============================================================================
module led_arbiter #(
  parameter int FLASH_TICKS = 500_000,    // 1..2^24
  parameter int IDLE_TICKS  = 10_000_000  // 1..2^24
) (
  input  logic          clock,
  input  logic          reset_b,
  led_arbiter_if.slave  bus
);

  // Encoding doubles as the owner output code.
  typedef enum logic [1:0] {
    ST_ANIM  = 2'b00,
    ST_CPU   = 2'b01,
    ST_FLASH = 2'b10
  } state_t;

  localparam logic [23:0] c_flash_load = 24'(FLASH_TICKS - 1);
  localparam logic [23:0] c_idle_last  = 24'(IDLE_TICKS - 1);

  state_t      r_state,      w_state_nxt;
  logic        r_ret_cpu,    w_ret_cpu_nxt;   // return state after FLASH: 1 = CPU
  logic [23:0] r_timer,      w_timer_nxt;     // idle count in CPU, remaining flash in FLASH
  logic [7:0]  r_cpu_latch,  w_cpu_latch_nxt;
  logic [7:0]  r_flash_latch, w_flash_nxt;
  logic [7:0]  r_leds,       w_leds_nxt;
  logic [1:0]  r_owner;
  logic        r_animating;
  logic        r_flash_busy;

  always_comb begin
    w_cpu_latch_nxt = bus.cpu_we ? bus.cpu_data : r_cpu_latch;
    w_state_nxt     = r_state;
    w_ret_cpu_nxt   = r_ret_cpu;
    w_timer_nxt     = r_timer;
    w_flash_nxt     = r_flash_latch;
    w_leds_nxt      = 8'h00;

    unique case (r_state)
      ST_ANIM: begin
        if (bus.flash_req) begin
          w_state_nxt   = ST_FLASH;
          w_ret_cpu_nxt = bus.cpu_we;
          w_flash_nxt   = bus.flash_pattern;
          w_timer_nxt   = c_flash_load;
        end else if (bus.cpu_we || !bus.anim_enable) begin
          w_state_nxt = ST_CPU;
          w_timer_nxt = 24'd0;
        end
      end

      ST_CPU: begin
        if (bus.flash_req) begin
          w_state_nxt   = ST_FLASH;
          w_ret_cpu_nxt = 1'b1;
          w_flash_nxt   = bus.flash_pattern;
          w_timer_nxt   = c_flash_load;
        end else if (bus.cpu_we) begin
          w_timer_nxt = 24'd0;
        end else if (r_timer == c_idle_last) begin
          // Idle expired: hand back to animation if allowed, else hold
          // the saturated count so the handover happens as soon as it is.
          if (bus.anim_enable) begin
            w_state_nxt = ST_ANIM;
            w_timer_nxt = 24'd0;
          end
        end else begin
          w_timer_nxt = r_timer + 24'd1;
        end
      end

      ST_FLASH: begin
        // flash_req is deliberately ignored here: no retrigger.
        if (bus.cpu_we) w_ret_cpu_nxt = 1'b1;
        if (r_timer == 24'd0) begin
          // A write in the final flash cycle still redirects the return.
          if (w_ret_cpu_nxt || !bus.anim_enable) w_state_nxt = ST_CPU;
          else                                   w_state_nxt = ST_ANIM;
          w_timer_nxt = 24'd0;
        end else begin
          w_timer_nxt = r_timer - 24'd1;
        end
      end

      default: begin
        w_state_nxt = ST_ANIM;
        w_timer_nxt = 24'd0;
      end
    endcase

    // Source select on the next state so outputs change on the same edge.
    unique case (w_state_nxt)
      ST_ANIM:  w_leds_nxt = bus.anim_leds;
      ST_CPU:   w_leds_nxt = w_cpu_latch_nxt;
      ST_FLASH: w_leds_nxt = w_flash_nxt;
      default:  w_leds_nxt = 8'h00;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_b) begin
      r_state       <= ST_ANIM;
      r_ret_cpu     <= 1'b0;
      r_timer       <= 24'd0;
      r_cpu_latch   <= 8'h00;
      r_flash_latch <= 8'h00;
      r_leds        <= 8'h00;
      r_owner       <= 2'b00;
      r_animating   <= 1'b1;
      r_flash_busy  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ret_cpu     <= w_ret_cpu_nxt;
      r_timer       <= w_timer_nxt;
      r_cpu_latch   <= w_cpu_latch_nxt;
      r_flash_latch <= w_flash_nxt;
      r_leds        <= w_leds_nxt;
      r_owner       <= w_state_nxt;
      r_animating   <= (w_state_nxt == ST_ANIM);
      r_flash_busy  <= (w_state_nxt == ST_FLASH);
    end
  end

  assign bus.leds       = r_leds;
  assign bus.owner      = r_owner;
  assign bus.animating  = r_animating;
  assign bus.flash_busy = r_flash_busy;

endmodule
`default_nettype wire

// File: tb/tb_led_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_arbiter
// Description : Self-checking bench for led_arbiter (FLASH_TICKS=4,
//               IDLE_TICKS=8). A table of one-edge records {inputs, expected
//               leds/owner} is applied in order; a hand-written reset and
//               simultaneous-event sequence runs first.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_arbiter;

  logic clk;
  logic rst_b;
  int   n_checks;
  int   n_errors;

  led_arbiter_if bus ();

  led_arbiter #(
    .FLASH_TICKS (4),
    .IDLE_TICKS  (8)
  ) dut (
    .clock   (clk),
    .reset_b (rst_b),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_b;
    logic       ae;
    logic [7:0] al;
    logic       we;
    logic [7:0] wd;
    logic       fr;
    logic [7:0] fp;
    logic [7:0] e_leds;
    logic [1:0] e_owner;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rb, input logic ae, input logic [7:0] al,
                     input logic we, input logic [7:0] wd,
                     input logic fr, input logic [7:0] fp,
                     input logic [7:0] el, input logic [1:0] eo);
    vec_t v;
    v.rst_b = rb; v.ae = ae; v.al = al; v.we = we; v.wd = wd;
    v.fr = fr; v.fp = fp; v.e_leds = el; v.e_owner = eo;
    vecs.push_back(v);
  endtask

  // n quiet edges with the given animation inputs and expectation
  task automatic idle(input int n, input logic ae, input logic [7:0] al,
                      input logic [7:0] el, input logic [1:0] eo);
    for (int k = 0; k < n; k++) add(1'b1, ae, al, 1'b0, 8'h00, 1'b0, 8'h00, el, eo);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rb, input logic ae, input logic [7:0] al,
                       input logic we, input logic [7:0] wd,
                       input logic fr, input logic [7:0] fp);
    rst_b             = rb;
    bus.anim_enable   = ae;
    bus.anim_leds     = al;
    bus.cpu_we        = we;
    bus.cpu_data      = wd;
    bus.flash_req     = fr;
    bus.flash_pattern = fp;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] el, input logic [1:0] eo);
    chk({tag, " leds"},       int'(bus.leds),       int'(el));
    chk({tag, " owner"},      int'(bus.owner),      int'(eo));
    chk({tag, " animating"},  int'(bus.animating),  int'(eo == 2'b00));
    chk({tag, " flash_busy"}, int'(bus.flash_busy), int'(eo == 2'b10));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    drive(1'b0, 1'b1, 8'hA5, 1'b1, 8'h77, 1'b1, 8'h99);

    // ---- Hand sequence 1: reset overrides active inputs ----
    step();
    step();
    expect_out("reset", 8'h00, 2'b00);

    // ---- Hand sequence 2: first post-reset edge with flash_req + cpu_we ----
    drive(1'b1, 1'b1, 8'hA5, 1'b1, 8'h66, 1'b1, 8'h5A);
    step();
    expect_out("post-reset flash entry", 8'h5A, 2'b10);
    drive(1'b1, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      step();
      expect_out($sformatf("post-reset flash hold %0d", k), 8'h5A, 2'b10);
    end
    step();
    expect_out("post-reset flash exit to cpu", 8'h66, 2'b01);

    // ---- Table: reset, then animation for 20 cycles ----
    add(1'b0, 1'b1, 8'hA5, 1'b1, 8'h77, 1'b1, 8'h99, 8'h00, 2'b00);
    idle(20, 1'b1, 8'hA5, 8'hA5, 2'b00);
    // CPU write then idle timeout back to animation on the 8th idle edge
    add(1'b1, 1'b1, 8'hA5, 1'b1, 8'h3C, 1'b0, 8'h00, 8'h3C, 2'b01);
    idle(7, 1'b1, 8'hA5, 8'h3C, 2'b01);
    idle(1, 1'b1, 8'h5A, 8'h5A, 2'b00);
    // Flash from CPU, retrigger ignored, return to CPU with fresh idle timer
    add(1'b1, 1'b1, 8'h5A, 1'b1, 8'h3C, 1'b0, 8'h00, 8'h3C, 2'b01);
    add(1'b1, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b1, 8'hFF, 8'hFF, 2'b10);
    add(1'b1, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b1, 8'h0F, 8'hFF, 2'b10);
    idle(2, 1'b1, 8'h5A, 8'hFF, 2'b10);
    idle(8, 1'b1, 8'h5A, 8'h3C, 2'b01);
    idle(1, 1'b1, 8'h5A, 8'h5A, 2'b00);
    // Simultaneous flash_req + cpu_we in ANIM
    add(1'b1, 1'b1, 8'h5A, 1'b1, 8'h11, 1'b1, 8'hF0, 8'hF0, 2'b10);
    idle(3, 1'b1, 8'h5A, 8'hF0, 2'b10);
    idle(8, 1'b1, 8'h5A, 8'h11, 2'b01);
    idle(1, 1'b1, 8'h5A, 8'h5A, 2'b00);
    // Flash from ANIM redirected to CPU by a mid-flash write
    add(1'b1, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b1, 8'hF0, 8'hF0, 2'b10);
    add(1'b1, 1'b1, 8'h5A, 1'b1, 8'h22, 1'b0, 8'h00, 8'hF0, 2'b10);
    idle(2, 1'b1, 8'h5A, 8'hF0, 2'b10);
    idle(8, 1'b1, 8'h5A, 8'h22, 2'b01);
    idle(1, 1'b1, 8'h5A, 8'h5A, 2'b00);
    // Plain flash from ANIM returns to ANIM
    add(1'b1, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b1, 8'hC3, 8'hC3, 2'b10);
    idle(3, 1'b1, 8'h5A, 8'hC3, 2'b10);
    idle(1, 1'b1, 8'h5A, 8'h5A, 2'b00);
    // Flash from ANIM with anim_enable dropped: returns to CPU
    add(1'b1, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b1, 8'h81, 8'h81, 2'b10);
    idle(3, 1'b0, 8'h5A, 8'h81, 2'b10);
    idle(1, 1'b0, 8'h5A, 8'h22, 2'b01);
    // Idle timer saturates with anim_enable low, releases immediately
    idle(12, 1'b0, 8'h5A, 8'h22, 2'b01);
    idle(1, 1'b1, 8'h5A, 8'h5A, 2'b00);
    // anim_enable low in ANIM -> CPU; write at timer limit beats timeout
    idle(1, 1'b0, 8'h5A, 8'h22, 2'b01);
    idle(7, 1'b1, 8'h5A, 8'h22, 2'b01);
    add(1'b1, 1'b1, 8'h5A, 1'b1, 8'h44, 1'b0, 8'h00, 8'h44, 2'b01);
    idle(7, 1'b1, 8'h5A, 8'h44, 2'b01);
    idle(1, 1'b1, 8'h5A, 8'h5A, 2'b00);
    // Reset during FLASH with cpu_we: everything cleared, cpu_latch 00
    add(1'b1, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b1, 8'hEE, 8'hEE, 2'b10);
    add(1'b0, 1'b1, 8'h5A, 1'b1, 8'h99, 1'b1, 8'h77, 8'h00, 2'b00);
    idle(1, 1'b0, 8'h5A, 8'h00, 2'b01);
    idle(1, 1'b1, 8'h5A, 8'h00, 2'b01);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_b, vecs[i].ae, vecs[i].al, vecs[i].we, vecs[i].wd,
            vecs[i].fr, vecs[i].fp);
      step();
      expect_out($sformatf("row %0d", i), vecs[i].e_leds, vecs[i].e_owner);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_arbiter.md
LED_ARBITER -- requirements
Module: led_arbiter

Interface
REQ-001 Parameter FLASH_TICKS, default 500_000: cycles a flash pattern is held; legal range 1..2^24.
REQ-002 Parameter IDLE_TICKS, default 10_000_000: CPU-idle cycles before the LEDs return to animation; legal range 1..2^24.
REQ-003 clock  input  1  sole clock; all state changes on the rising edge.
REQ-004 reset_b  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
REQ-005 anim_enable  input  1  animation source is permitted to own the LEDs.
REQ-006 anim_leds  input  8  pattern from the animation engine.
REQ-007 cpu_we  input  1  single-cycle CPU write strobe.
REQ-008 cpu_data  input  8  CPU LED value, valid when cpu_we=1.
REQ-009 flash_req  input  1  single-cycle request to show a temporary pattern.
REQ-010 flash_pattern  input  8  flash value, valid when flash_req=1.
REQ-011 leds  output  8  registered LED drive.
REQ-012 animating  output  1  high when the owner is ANIM.
REQ-013 owner  output  2  current owner: 00 ANIM, 01 CPU, 10 FLASH; 11 never driven.
REQ-014 flash_busy  output  1  high when the owner is FLASH.

Function
REQ-015 State machine states SHALL be ANIM, CPU and FLASH, with a registered return state ret (ANIM or CPU) plus a 24-bit timer.
REQ-016 A cpu_we in any state SHALL load cpu_latch <= cpu_data at that edge.
REQ-017 ANIM: flash_req -> FLASH with ret=CPU if cpu_we is also high, else ret=ANIM; otherwise cpu_we -> CPU; otherwise anim_enable=0 -> CPU; otherwise stay.
REQ-018 CPU: flash_req -> FLASH with ret=CPU; otherwise the idle timer behaves as follows:
- it clears on cpu_we;
- it increments each cycle without cpu_we;
- when it is at IDLE_TICKS-1 with anim_enable=1 -> ANIM;
- when it is at IDLE_TICKS-1 with anim_enable=0 it saturates and the state stays CPU.
REQ-019 Entering FLASH SHALL latch flash_pattern and load timer=FLASH_TICKS-1.
REQ-020 FLASH: the timer decrements each cycle; at timer=0 the next state is ret, except ret=ANIM with anim_enable=0 -> CPU.
REQ-021 FLASH: flash_req SHALL be ignored (no retrigger, pattern unchanged).
REQ-022 FLASH: cpu_we SHALL update cpu_latch and set ret=CPU.
REQ-023 Priority on simultaneous events SHALL be flash_req > cpu_we > idle timeout / anim_enable.
REQ-024 Entering CPU from any state SHALL clear the idle timer.
REQ-025 leds, owner, animating and flash_busy SHALL be registered and reflect the next state at the same edge the state changes (zero added latency beyond one register).
REQ-026 leds SHALL select the source by next state:
- ANIM: anim_leds sampled at that edge;
- CPU: cpu_latch including any same-edge write, so a CPU write appears on leds at the edge it is sampled;
- FLASH: the flash latch.
REQ-027 Counters SHALL never wrap; FLASH_TICKS=1 yields exactly one cycle of FLASH.

Reset
REQ-028 reset_b=0 at an edge SHALL force: state ANIM, ret ANIM, timers 0, cpu_latch 00, flash latch 00, leds 00, owner 00, animating 1, flash_busy 0.
REQ-029 Reset SHALL override all inputs, including mid-flash and same-cycle cpu_we/flash_req; the first post-reset edge follows REQ-017.

Verification (FLASH_TICKS=4, IDLE_TICKS=8)
REQ-030 Reset, then anim_leds=A5 with anim_enable=1 and no other activity for 20 cycles -> leds=A5, owner=00, animating=1 throughout.
REQ-031 cpu_we with cpu_data=3C, then 7 idle cycles -> leds=3C and owner=01 from the write edge; at the 8th idle edge owner=00 and leds=anim_leds.
REQ-032 In CPU showing 3C, flash_req with flash_pattern=FF -> leds=FF and flash_busy=1 for exactly 4 cycles; flash_req pulsed again during flash has no effect; then leds=3C and owner=01 with the idle timer restarted.
REQ-033 Same-cycle flash_req (F0) and cpu_we (11) in ANIM -> 4 cycles of F0, then owner=01 and leds=11; cpu_we=22 mid-flash -> after the flash leds=22.
REQ-034 anim_enable=0 in ANIM -> next edge owner=01 with leds=cpu_latch; idle past 8 cycles -> owner stays 01.
REQ-035 reset_b=0 asserted during FLASH, coinciding with cpu_we -> next edge leds=00, owner=00, flash_busy=0, cpu_latch=00.
